// File: rtl/imem_loader_pkg.sv
// -----------------------------------------------------------------------------
// imem_loader_pkg
// Shared definitions for the instruction-memory loader:
//   loader_state_t  - loader FSM state encoding
//   DEFAULT_DEPTH   - default instruction-memory capacity in 32-bit words
//   BIG_ENDIAN      - byte order of words stored in the instruction memory
//   shift_in_byte   - appends one stream byte to a partially assembled word
// -----------------------------------------------------------------------------
package imem_loader_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        HDR  = 3'd1,
        DATA = 3'd2,
        CSUM = 3'd3,
        DONE = 3'd4,
        ERR  = 3'd5
    } loader_state_t;

    localparam int DEFAULT_DEPTH = 128;

    // The instruction memory holds words with the first stream byte in the
    // most significant position.
    localparam bit BIG_ENDIAN = 1'b1;

    // Big-endian streams shift bytes in from the bottom so the first byte
    // ends up in bits 31:24; little-endian streams shift in from the top.
    function automatic logic [31:0] shift_in_byte(
        input logic [31:0] word,
        input logic [7:0]  new_byte,
        input bit          big_endian
    );
        if (big_endian) begin
            return {word[23:0], new_byte};
        end
        return {new_byte, word[31:8]};
    endfunction

endpackage

// File: rtl/imem_loader_byte_packer.sv
// -----------------------------------------------------------------------------
// byte_packer
// Collects bytes into 32-bit words. Every fourth accepted byte completes a
// word; word_valid pulses for exactly the following cycle while word_data
// holds the completed word.
// Ports:
//   clk, reset   - clock, asynchronous active-high reset
//   clear        - synchronous restart of the byte count and shift register
//   byte_valid   - byte_data is accepted this cycle
//   byte_data    - incoming byte
//   byte_cnt     - number of bytes already held for the current word (0..3)
//   word_valid   - one-cycle pulse, word_data is a completed word
//   word_data    - shift register contents
// -----------------------------------------------------------------------------
module byte_packer
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic [1:0]  byte_cnt,
    output logic        word_valid,
    output logic [31:0] word_data
);

    logic [31:0] shift_reg;
    logic [1:0]  cnt;

    // Shift each accepted byte into the word; the 2-bit count wraps from 3
    // back to 0 on the fourth byte, which is the moment a word completes.
    // word_valid is registered so the pulse lands in the cycle after the
    // fourth byte, when shift_reg already contains it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shift_reg  <= 32'd0;
            cnt        <= 2'd0;
            word_valid <= 1'b0;
        end else begin
            word_valid <= 1'b0;
            if (clear) begin
                shift_reg <= 32'd0;
                cnt       <= 2'd0;
            end else if (byte_valid) begin
                shift_reg <= shift_in_byte(shift_reg, byte_data, BIG_ENDIAN);
                cnt       <= cnt + 2'd1;
                if (cnt == 2'd3) begin
                    word_valid <= 1'b1;
                end
            end
        end
    end

    assign byte_cnt  = cnt;
    assign word_data = shift_reg;

endmodule

// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
// Loads a program from a byte stream into instruction memory and holds the
// processor in reset until a load completes with a good checksum.
// Stream format: 2-byte word count N (MSB first), N big-endian 32-bit words,
// then 1 checksum byte equal to the XOR of all payload bytes.
// Ports:
//   clk, reset              - clock, asynchronous active-high reset
//   start                   - one-cycle request to begin a load
//   rx_valid, rx_data       - byte stream input
//   rx_ready                - loader accepts rx_data this cycle
//   mem_we, mem_addr,
//   mem_wdata               - instruction memory write port (byte address)
//   cpu_reset               - processor reset, low only after a good load
//   busy, done, error       - load status
//   words_loaded            - words written by the current or last load
// -----------------------------------------------------------------------------
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             rx_valid,
    input  logic [7:0]       rx_data,
    output logic             rx_ready,
    output logic             mem_we,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    output logic             cpu_reset,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [CNT_W-1:0] words_loaded
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    loader_state_t    state;
    loader_state_t    next_state;

    logic             receiving;
    logic             accept;
    logic             clear_load;
    logic             hdr_second;
    logic [CNT_W-1:0] n_reg;
    logic [CNT_W-1:0] header_n;
    logic             header_bad;
    logic [CNT_W-1:0] words_accepted;
    logic             last_word;
    logic [7:0]       csum;
    logic [1:0]       pack_cnt;
    logic             pack_byte;

    // Readiness depends on state alone, so the handshake never loops back
    // through rx_valid.
    assign receiving = (state == HDR) || (state == DATA) || (state == CSUM);
    assign rx_ready  = receiving;
    assign busy      = receiving;
    assign accept    = rx_valid && receiving;

    // The length is complete once the second header byte arrives, so the
    // range check looks at the value being formed this cycle.
    assign header_n   = {n_reg[CNT_W-9:0], rx_data};
    assign header_bad = (header_n == '0) || (header_n > CNT_W'(DEPTH));
    assign last_word  = (words_accepted == (n_reg - CNT_W'(1)));
    assign pack_byte  = (state == DATA) && accept;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and status decode. A start from IDLE, DONE or ERR restarts
    // the load; in the receiving states start is ignored.
    always_comb begin
        next_state = state;
        clear_load = 1'b0;
        done       = 1'b0;
        error      = 1'b0;
        cpu_reset  = 1'b1;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = HDR;
                    clear_load = 1'b1;
                end
            end
            HDR: begin
                if (accept && hdr_second) begin
                    next_state = header_bad ? ERR : DATA;
                end
            end
            DATA: begin
                if (accept && (pack_cnt == 2'd3) && last_word) begin
                    next_state = CSUM;
                end
            end
            CSUM: begin
                if (accept) begin
                    next_state = (rx_data == csum) ? DONE : ERR;
                end
            end
            DONE: begin
                done      = 1'b1;
                cpu_reset = 1'b0;
                if (start) begin
                    next_state = HDR;
                    clear_load = 1'b1;
                end
            end
            ERR: begin
                error = 1'b1;
                if (start) begin
                    next_state = HDR;
                    clear_load = 1'b1;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Header length, checksum accumulator and word counters. words_accepted
    // tracks completed words as their last byte arrives (drives the move to
    // CSUM); words_loaded counts actual memory writes and also supplies the
    // write address, so it steps once at the end of each mem_we cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            n_reg          <= '0;
            hdr_second     <= 1'b0;
            words_accepted <= '0;
            csum           <= 8'd0;
            words_loaded   <= '0;
        end else if (clear_load) begin
            n_reg          <= '0;
            hdr_second     <= 1'b0;
            words_accepted <= '0;
            csum           <= 8'd0;
            words_loaded   <= '0;
        end else begin
            if ((state == HDR) && accept) begin
                n_reg      <= header_n;
                hdr_second <= 1'b1;
            end
            if (pack_byte) begin
                csum <= csum ^ rx_data;
                if (pack_cnt == 2'd3) begin
                    words_accepted <= words_accepted + CNT_W'(1);
                end
            end
            if (mem_we) begin
                words_loaded <= words_loaded + CNT_W'(1);
            end
        end
    end

    byte_packer u_byte_packer (
        .clk        (clk),
        .reset      (reset),
        .clear      (clear_load),
        .byte_valid (pack_byte),
        .byte_data  (rx_data),
        .byte_cnt   (pack_cnt),
        .word_valid (mem_we),
        .word_data  (mem_wdata)
    );

    // Word index wraps within DEPTH; the length check keeps real writes
    // below DEPTH.
    assign mem_addr = {{(30 - AW){1'b0}}, words_loaded[AW-1:0], 2'b00};

endmodule

// File: tb/tb_imem_loader.sv
// -----------------------------------------------------------------------------
// tb_imem_loader
// Self-checking bench for imem_loader. Stimulus tasks push the expected memory
// writes into a queue; a monitor pops and compares each write as mem_we is
// seen. Status outputs are compared after each load.
// -----------------------------------------------------------------------------
module tb_imem_loader;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } write_t;

    logic        clk;
    logic        reset;
    logic        start;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        cpu_reset;
    logic        busy;
    logic        done;
    logic        error;
    logic [15:0] words_loaded;

    int          assertions;
    int          failures;
    int          ready_drops;
    bit          in_load;
    write_t      exp_q[$];
    logic [31:0] prog_words[4];

    imem_loader dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .rx_valid     (rx_valid),
        .rx_data      (rx_data),
        .rx_ready     (rx_ready),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .cpu_reset    (cpu_reset),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .words_loaded (words_loaded)
    );

    // 10-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard time limit so the run always ends.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        assertions++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, actual, expected);
        end
    endtask

    // Monitor: every write strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                assertions++;
                failures++;
                $display("[TB] FAIL unexpected_write: got addr 0x%0h data 0x%0h, want no write",
                         mem_addr, mem_wdata);
            end else begin
                write_t w;
                w = exp_q.pop_front();
                checkOutput("write_addr", mem_addr, w.addr);
                checkOutput("write_data", mem_wdata, w.data);
            end
        end
        if (in_load && (rx_ready !== 1'b1)) begin
            ready_drops++;
        end
    end

    // Offers one byte, optionally preceded by random idle cycles, and waits
    // (bounded) until the loader takes it.
    task automatic applyStimulus(input logic [7:0] b, input bit stall);
        int guard;
        guard = 0;
        if (stall) begin
            for (int k = 0; k < 4; k++) begin
                if ($urandom_range(1, 0) == 0) break;
                rx_valid = 1'b0;
                @(posedge clk);
                #1;
            end
        end
        rx_valid = 1'b1;
        rx_data  = b;
        forever begin
            @(negedge clk);
            if (rx_ready === 1'b1) begin
                @(posedge clk);
                #1;
                break;
            end
            guard++;
            if (guard > 20) begin
                assertions++;
                failures++;
                $display("[TB] FAIL byte_accept_timeout: got rx_ready 0 for 20 cycles, want 1");
                break;
            end
        end
        rx_valid = 1'b0;
    endtask

    task automatic pulseStart();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Full load of nw words from prog_words. start_at >= 0 pulses start
    // before that payload byte, which must have no effect.
    task automatic runLoad(input int nw, input logic [7:0] csum, input bit stall,
                           input int start_at, input bit expect_ok);
        logic [15:0] hdr;
        hdr = 16'(nw);
        pulseStart();
        checkOutput("start_cpu_reset", 32'(cpu_reset), 32'd1);
        checkOutput("start_busy", 32'(busy), 32'd1);
        ready_drops = 0;
        in_load = 1'b1;
        applyStimulus(hdr[15:8], stall);
        applyStimulus(hdr[7:0], stall);
        for (int i = 0; i < nw; i++) begin
            exp_q.push_back('{addr: 32'(4 * i), data: prog_words[i]});
            for (int b = 0; b < 4; b++) begin
                if ((i * 4 + b) == start_at) pulseStart();
                applyStimulus(prog_words[i][31 - 8 * b -: 8], stall);
            end
        end
        applyStimulus(csum, stall);
        in_load = 1'b0;
        checkOutput("rx_ready_drops_in_load", 32'(ready_drops), 32'd0);
        checkOutput("end_done", 32'(done), 32'(expect_ok));
        checkOutput("end_error", 32'(error), 32'(!expect_ok));
        checkOutput("end_cpu_reset", 32'(cpu_reset), 32'(!expect_ok));
        checkOutput("end_busy", 32'(busy), 32'd0);
        checkOutput("end_rx_ready", 32'(rx_ready), 32'd0);
        checkOutput("end_words_loaded", 32'(words_loaded), 32'(nw));
    endtask

    // Header-only load that must be rejected right after the second byte.
    task automatic runBadHeader(input logic [15:0] hdr);
        pulseStart();
        applyStimulus(hdr[15:8], 1'b0);
        applyStimulus(hdr[7:0], 1'b0);
        checkOutput("bad_hdr_error", 32'(error), 32'd1);
        checkOutput("bad_hdr_busy", 32'(busy), 32'd0);
        checkOutput("bad_hdr_cpu_reset", 32'(cpu_reset), 32'd1);
        checkOutput("bad_hdr_words_loaded", 32'(words_loaded), 32'd0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic loadTwoWordProgram();
        prog_words[0] = 32'h8C01_0004;
        prog_words[1] = 32'h0022_1820;
    endtask

    task automatic loadThreeWordProgram();
        prog_words[0] = 32'h2008_0005;
        prog_words[1] = 32'h8C09_0000;
        prog_words[2] = 32'h0109_5020;
    endtask

    initial begin
        assertions  = 0;
        failures    = 0;
        ready_drops = 0;
        in_load     = 1'b0;
        reset       = 1'b1;
        start       = 1'b0;
        rx_valid    = 1'b0;
        rx_data     = 8'h00;

        // Reset values.
        #12;
        checkOutput("rst_cpu_reset", 32'(cpu_reset), 32'd1);
        checkOutput("rst_rx_ready", 32'(rx_ready), 32'd0);
        checkOutput("rst_mem_we", 32'(mem_we), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_error", 32'(error), 32'd0);
        checkOutput("rst_words_loaded", 32'(words_loaded), 32'd0);
        checkOutput("rst_mem_addr", mem_addr, 32'd0);
        checkOutput("rst_mem_wdata", mem_wdata, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Two-word program. XOR of 8C 01 00 04 00 22 18 20 is 0x93.
        $display("[TB] two-word load, good checksum");
        loadTwoWordProgram();
        runLoad(2, 8'h93, 1'b0, -1, 1'b1);

        // Restart from DONE with a wrong checksum; rewrites from address 0.
        $display("[TB] two-word load, checksum 00");
        runLoad(2, 8'h00, 1'b0, -1, 1'b0);

        // 0xAE does not equal the XOR of the payload either.
        $display("[TB] two-word load, checksum AE");
        runLoad(2, 8'hAE, 1'b0, -1, 1'b0);

        $display("[TB] header N=0 and N=129");
        runBadHeader(16'h0000);
        runBadHeader(16'h0081);

        // Three-word program. XOR of all twelve payload bytes is 0xD0.
        $display("[TB] three-word load, unstalled then stalled");
        loadThreeWordProgram();
        runLoad(3, 8'hD0, 1'b0, -1, 1'b1);
        runLoad(3, 8'hD0, 1'b1, -1, 1'b1);

        $display("[TB] start pulsed during payload");
        loadTwoWordProgram();
        runLoad(2, 8'h93, 1'b0, 2, 1'b1);

        // Reset after six payload bytes: the first word has been written.
        $display("[TB] reset mid-load");
        pulseStart();
        applyStimulus(8'h00, 1'b0);
        applyStimulus(8'h02, 1'b0);
        exp_q.push_back('{addr: 32'd0, data: 32'h8C01_0004});
        for (int b = 0; b < 6; b++) begin
            applyStimulus((b < 4) ? prog_words[0][31 - 8 * b -: 8]
                                  : prog_words[1][63 - 8 * b -: 8], 1'b0);
        end
        #2;
        reset = 1'b1;
        #1;
        checkOutput("midrst_cpu_reset", 32'(cpu_reset), 32'd1);
        checkOutput("midrst_rx_ready", 32'(rx_ready), 32'd0);
        checkOutput("midrst_mem_we", 32'(mem_we), 32'd0);
        checkOutput("midrst_busy", 32'(busy), 32'd0);
        checkOutput("midrst_done", 32'(done), 32'd0);
        checkOutput("midrst_error", 32'(error), 32'd0);
        checkOutput("midrst_words_loaded", 32'(words_loaded), 32'd0);
        checkOutput("midrst_mem_addr", mem_addr, 32'd0);
        checkOutput("midrst_mem_wdata", mem_wdata, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        runLoad(2, 8'h93, 1'b0, -1, 1'b1);

        repeat (3) @(posedge clk);
        #1;
        checkOutput("pending_writes", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
